// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: shares one single-precision multiplier among NREQ requesters.
// Only one operation is outstanding at a time. Requesters are granted round-robin,
// starting after the last granted requester. The operation is then issued with a
// start pulse, and the design waits for done under a watchdog. The result is
// returned tagged with the owner's ID.
//
// Ports
//   CLK, RST          clock; asynchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot, IDLE only)
//   req_a, req_b      packed operands, requester i at [32i+31:32i]
//   mul_a, mul_b      latched operands held from ISSUE through RESP
//   mul_start         one-cycle start pulse
//   mul_clr           one-cycle abort pulse on watchdog expiry
//   mul_done          done strobe, with mul_result/mul_ovf/mul_unf
//   rsp_*             response channel (valid/ready) with ID, result and flags
//   busy              high in any state but IDLE
module fp_mult_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic                 mul_start,
  output logic                 mul_clr,
  input  logic                 mul_done,
  input  logic [31:0]          mul_result,
  input  logic                 mul_ovf,
  input  logic                 mul_unf,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_ovf,
  output logic                 rsp_unf,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e         r_state, w_state_next;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] r_id;
  logic [31:0]    r_a, r_b;
  logic [7:0]     r_wd;
  logic [31:0]    r_result;
  logic           r_ovf, r_unf, r_err;

  logic           w_any;
  logic [IDW-1:0] w_gnt;
  logic           w_timeout;

  // Round-robin search starting one past the last grant.
  always_comb begin
    int unsigned v_idx;
    v_idx = 0;
    w_any = 1'b0;
    w_gnt = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      v_idx = (32'(r_last_grant) + i) % NREQ;
      if (!w_any && req_valid[v_idx[IDW-1:0]]) begin
        w_any = 1'b1;
        w_gnt = v_idx[IDW-1:0];
      end
    end
  end

  // Watchdog holds (WAIT cycle - 1), so this fires on the TIMEOUT-th WAIT cycle.
  assign w_timeout = (r_wd == 8'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    mul_start    = 1'b0;
    mul_clr      = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_any) begin
          req_ready[w_gnt] = 1'b1;
          w_state_next     = StIssue;
        end
      end
      StIssue: begin
        mul_start    = 1'b1;
        w_state_next = StWait;
      end
      StWait: begin
        // done has priority over a coincident timeout
        if (mul_done) begin
          w_state_next = StResp;
        end else if (w_timeout) begin
          mul_clr      = 1'b1;
          w_state_next = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last_grant <= IDW'(NREQ - 1);
      r_id         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_wd         <= '0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_a  <= req_a[32*int'(w_gnt) +: 32];
            r_b  <= req_b[32*int'(w_gnt) +: 32];
            r_id <= w_gnt;
          end
        end
        StIssue: begin
          r_wd <= '0;
        end
        StWait: begin
          r_wd <= r_wd + 8'd1;
          if (mul_done) begin
            r_result <= mul_result;
            r_ovf    <= mul_ovf;
            r_unf    <= mul_unf;
            r_err    <= 1'b0;
          end else if (w_timeout) begin
            r_result <= QNaN;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_err    <= 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            r_last_grant <= r_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_a      = r_a;
  assign mul_b      = r_b;
  assign rsp_valid  = (r_state == StResp);
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_ovf    = r_ovf;
  assign rsp_unf    = r_unf;
  assign rsp_err    = r_err;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Self-checking bench for fp_mult_arbiter. A behavioural multiplier answers
// known operand pairs after a programmable number of WAIT cycles. Expected
// responses are queued by the stimulus and checked by a monitor on accept.
module tb_fp_mult_arbiter;

  localparam int NREQ = 4;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [32*NREQ-1:0]   req_a = '0;
  logic [32*NREQ-1:0]   req_b = '0;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          mul_a, mul_b;
  logic                 mul_start, mul_clr;
  logic                 mul_done = 1'b0;
  logic [31:0]          mul_result = '0;
  logic                 mul_ovf = 1'b0;
  logic                 mul_unf = 1'b0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [1:0]           rsp_id;
  logic [31:0]          rsp_result;
  logic                 rsp_ovf, rsp_unf, rsp_err;
  logic                 busy;

  fp_mult_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT(63)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_start  (mul_start),
    .mul_clr    (mul_clr),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .mul_ovf    (mul_ovf),
    .mul_unf    (mul_unf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf),
    .rsp_unf    (rsp_unf),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_delay = 0;  // WAIT cycle on which the model asserts done; 0 = never

  logic [31:0] rr_a   [4] = '{32'h4000_0000, 32'h3FC0_0000, 32'hC000_0000, 32'h3F00_0000};
  logic [31:0] rr_b   [4] = '{32'h4040_0000, 32'h4000_0000, 32'h4080_0000, 32'h3F00_0000};
  logic [31:0] rr_res [4] = '{32'h40C0_0000, 32'h4040_0000, 32'hC100_0000, 32'h3E80_0000};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hand-computed products: {ovf, unf, result}
  function automatic logic [33:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h4000_0000, 32'h4040_0000}: return {2'b00, 32'h40C0_0000};  // 2.0 * 3.0
      {32'h3FC0_0000, 32'h4000_0000}: return {2'b00, 32'h4040_0000};  // 1.5 * 2.0
      {32'hC000_0000, 32'h4080_0000}: return {2'b00, 32'hC100_0000};  // -2.0 * 4.0
      {32'h3F00_0000, 32'h3F00_0000}: return {2'b00, 32'h3E80_0000};  // 0.5 * 0.5
      {32'h7F00_0000, 32'h4000_0000}: return {2'b10, 32'h7F80_0000};  // 2^127 * 2 -> inf
      {32'h0080_0000, 32'h3F00_0000}: return {2'b01, 32'h0040_0000};  // 2^-126 * 0.5
      default:                        return {2'b00, 32'hDEAD_BEEF};
    endcase
  endfunction

  // Multiplier model: sees the start pulse, answers on WAIT cycle done_delay.
  initial begin
    logic [33:0] r;
    int          d;
    forever begin
      @(negedge CLK);
      if (mul_start) begin
        r = mul_ref(mul_a, mul_b);
        d = done_delay;
        if (d > 0) begin
          repeat (d) @(posedge CLK);
          #1;
          mul_done = 1'b1;
          {mul_ovf, mul_unf, mul_result} = r;
          @(posedge CLK);
          #1;
          mul_done   = 1'b0;
          mul_ovf    = 1'b0;
          mul_unf    = 1'b0;
          mul_result = '0;
        end
      end
    end
  end

  // Scoreboard monitor: compares each accepted response against the queue head.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (!RST && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {rsp_id, rsp_result}, '0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_flags", {rsp_ovf, rsp_unf, rsp_err}, {e.ovf, e.unf, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #3;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 300) begin
      tick();
      c++;
    end
    chk("wait_idle", busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ctl"}, {req_ready, mul_start, mul_clr, rsp_valid, busy}, '0);
    chk({tag, "_ops"}, {mul_a, mul_b}, '0);
    chk({tag, "_rsp"}, {rsp_result, rsp_id, rsp_ovf, rsp_unf, rsp_err}, '0);
  endtask

  // One isolated transaction; latency counted from the grant cycle.
  task automatic run_single(input int id, input logic [31:0] a, input logic [31:0] b,
                            input int delay, input logic [31:0] res, input logic ovf,
                            input logic unf, input logic err, input int exp_lat,
                            input int exp_clr_at);
    int         lat, clr_cnt, clr_at, extra;
    logic [3:0] onehot;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    done_delay = delay;
    rsp_ready  = 1'b1;
    onehot     = 4'b0001 << id;
    exp_q.push_back(exp_t'({2'(id), res, ovf, unf, err}));
    req_valid = onehot;
    #1;
    chk("grant", req_ready, onehot);
    tick();
    chk("start_pulse", {mul_start, busy, req_ready}, {2'b11, 4'b0000});
    req_valid = '0;
    lat = 1;
    clr_cnt = 0;
    clr_at = 0;
    extra = 0;
    do begin
      tick();
      lat++;
      if (mul_clr) begin
        clr_cnt++;
        clr_at = lat;
      end
      if (mul_start) extra++;
    end while (!rsp_valid && lat < 300);
    chk("latency", lat, exp_lat);
    chk("start_once", extra, 0);
    chk("clr_count", clr_cnt, (exp_clr_at != 0) ? 1 : 0);
    if (exp_clr_at != 0) chk("clr_cycle", clr_at, exp_clr_at);
    tick();
  endtask

  initial begin
    int         c, bad_rdy, cnt_v, cnt_b;
    logic [127:0] snap;

    // Reset values while RST is held
    tick();
    tick();
    check_reset_values("reset");
    RST = 1'b0;
    tick();

    // Single request: 2.0 * 3.0, done on WAIT cycle 5 -> rsp_valid at T+7
    run_single(0, 32'h4000_0000, 32'h4040_0000, 5, 32'h40C0_0000, 1'b0, 1'b0, 1'b0, 7, 0);
    wait_idle();

    // Round-robin with all four requesting
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = rr_a[i];
      req_b[32*i +: 32] = rr_b[i];
    end
    rsp_ready  = 1'b1;
    done_delay = 2;
    req_valid  = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      exp_q.push_back(exp_t'({2'(n % 4), rr_res[n % 4], 3'b000}));
      c = 0;
      #1;
      while (req_ready == '0 && c < 100) begin
        tick();
        c++;
      end
      chk("rr_onehot", $countones(req_ready), 1);
      chk("rr_grant", req_ready, 4'b0001 << (n % 4));
      tick();
      if (n == 7) req_valid = '0;
    end
    wait_idle();

    // Backpressure: hold rsp_ready low for 10 cycles with requester 3 pending
    rsp_ready  = 1'b0;
    done_delay = 3;
    exp_q.push_back(exp_t'({2'd2, 32'hC100_0000, 3'b000}));
    req_valid = 4'b0100;
    #1;
    chk("bp_grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1000;
    exp_q.push_back(exp_t'({2'd3, 32'h3E80_0000, 3'b000}));
    c = 0;
    bad_rdy = 0;
    while (!rsp_valid && c < 100) begin
      if (req_ready != '0) bad_rdy++;
      tick();
      c++;
    end
    chk("bp_rsp_seen", rsp_valid, 1);
    snap = {rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_unf, rsp_err, mul_a, mul_b};
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req_ready != '0) bad_rdy++;
      chk("bp_stable", {rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_unf, rsp_err, mul_a, mul_b},
          snap);
    end
    chk("bp_ready_low", bad_rdy, 0);
    rsp_ready = 1'b1;
    tick();
    chk("bp_next_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    wait_idle();

    // Timeout: no done -> clr on WAIT cycle 63, error response on the next cycle
    run_single(1, 32'h3FC0_0000, 32'h4000_0000, 0, 32'h7FC0_0000, 1'b0, 1'b0, 1'b1, 65, 64);
    // Done on the timeout cycle wins: real result, no clr
    run_single(1, 32'h3FC0_0000, 32'h4000_0000, 63, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 65, 0);
    // Minimum latency with overflow, then underflow
    run_single(0, 32'h7F00_0000, 32'h4000_0000, 1, 32'h7F80_0000, 1'b1, 1'b0, 1'b0, 3, 0);
    run_single(2, 32'h0080_0000, 32'h3F00_0000, 4, 32'h0040_0000, 1'b0, 1'b1, 1'b0, 6, 0);

    // Reset mid-WAIT; the model's late done then lands in IDLE as a stray strobe
    rsp_ready  = 1'b1;
    done_delay = 20;
    req_valid  = 4'b1000;
    #1;
    chk("rst_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    repeat (5) tick();
    chk("rst_in_wait", busy, 1);
    RST = 1'b1;
    #1;
    check_reset_values("rst_mid");
    tick();
    tick();
    RST = 1'b0;
    cnt_v = 0;
    cnt_b = 0;
    repeat (25) begin
      tick();
      if (rsp_valid) cnt_v++;
      if (busy) cnt_b++;
    end
    chk("stray_done_rsp", cnt_v, 0);
    chk("stray_done_busy", cnt_b, 0);
    req_a[31:0] = 32'h4000_0000;
    req_b[31:0] = 32'h4040_0000;
    done_delay  = 2;
    exp_q.push_back(exp_t'({2'd0, 32'h40C0_0000, 3'b000}));
    req_valid = 4'b1111;
    #1;
    chk("rst_next_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    wait_idle();
    tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
